gtm: RTL and testbench

GTM -- requirements
Module: gtm

---
 rtl/gtm.sv | 192 +++++++++++++++++++
 tb/tb_gtm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gtm.sv
// Gate-time measurement controller.
// Handshakes with an external counter stage: raises a begin request, waits for
// the begin acknowledge, holds the gate open for the latched period, raises the
// end request and waits for the end acknowledge. Each handshake wait is bounded
// by a timeout counter; a timeout parks the block in an error state.
// All outputs are registered and derived from the next state.
module gtm #(
  parameter int size  = 32,
  parameter int wsize = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [size-1:0] per,
  input  logic            bac,
  input  logic            eac,
  output logic            brq,
  output logic            erq,
  output logic            bsy,
  output logic            rdy,
  output logic            tmo
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_GATE = 3'd2,
    S_STOP = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [size-1:0]  GATE_ONE  = size'(1);
  localparam logic [wsize-1:0] WAIT_ONE  = wsize'(1);
  // The wait counter holds (cycles spent in the state - 1); when it reads
  // 2^wsize-2 the current cycle is the (2^wsize-1)th one, i.e. the last chance
  // for the acknowledge before the timeout fires on the coming edge.
  localparam logic [wsize-1:0] WAIT_LAST = ~(wsize'(1));

  state_t           state_q, state_d;
  logic [size-1:0]  per_q, per_d;
  logic [size-1:0]  gate_q, gate_d;
  logic [wsize-1:0] wait_q, wait_d;

  logic brq_q, brq_d;
  logic erq_q, erq_d;
  logic bsy_q, bsy_d;
  logic rdy_q, rdy_d;
  logic tmo_q, tmo_d;

  // State, latched period and both counters; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      per_q   <= '0;
      gate_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      gate_q  <= gate_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and counter logic; dropping run overrides every other transition.
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    gate_d  = gate_q;
    wait_d  = wait_q;
    if (!run) begin
      state_d = S_IDLE;
      gate_d  = '0;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // A zero period would never reach the terminal count; treat it as 1.
          state_d = S_ARM;
          per_d   = (per == '0) ? GATE_ONE : per;
          wait_d  = '0;
        end
        S_ARM: begin
          // The acknowledge is tested first so that it wins on the timeout cycle.
          if (bac) begin
            state_d = S_GATE;
            gate_d  = per_q;
            wait_d  = '0;
          end else if (wait_q == WAIT_LAST) begin
            state_d = S_ERR;
          end else begin
            wait_d = wait_q + WAIT_ONE;
          end
        end
        S_GATE: begin
          // Terminal count is 1, so the counter never underflows or wraps.
          if (gate_q == GATE_ONE) begin
            state_d = S_STOP;
            gate_d  = '0;
            wait_d  = '0;
          end else begin
            gate_d = gate_q - GATE_ONE;
          end
        end
        S_STOP: begin
          if (eac) begin
            state_d = S_DONE;
            wait_d  = '0;
          end else if (wait_q == WAIT_LAST) begin
            state_d = S_ERR;
          end else begin
            wait_d = wait_q + WAIT_ONE;
          end
        end
        S_DONE, S_ERR: begin
          // Terminal until the host drops run; run staying high never restarts.
        end
        default: begin
          state_d = S_IDLE;
          gate_d  = '0;
          wait_d  = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track the state.
  always_comb begin
    brq_d = 1'b0;
    erq_d = 1'b0;
    bsy_d = 1'b0;
    rdy_d = 1'b0;
    tmo_d = 1'b0;
    unique case (state_d)
      S_ARM, S_GATE: begin
        brq_d = 1'b1;
        bsy_d = 1'b1;
      end
      S_STOP: begin
        brq_d = 1'b1;
        erq_d = 1'b1;
        bsy_d = 1'b1;
      end
      S_DONE: begin
        brq_d = 1'b1;
        erq_d = 1'b1;
        rdy_d = 1'b1;
      end
      S_ERR: begin
        tmo_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brq_q <= 1'b0;
      erq_q <= 1'b0;
      bsy_q <= 1'b0;
      rdy_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      brq_q <= brq_d;
      erq_q <= erq_d;
      bsy_q <= bsy_d;
      rdy_q <= rdy_d;
      tmo_q <= tmo_d;
    end
  end

  assign brq = brq_q;
  assign erq = erq_q;
  assign bsy = bsy_q;
  assign rdy = rdy_q;
  assign tmo = tmo_q;

  // Success and failure are mutually exclusive, and busy implies an open request.
  property p_rdy_tmo_excl;
    @(posedge clk) disable iff (rst) !(rdy_q && tmo_q);
  endproperty
  a_rdy_tmo_excl: assert property (p_rdy_tmo_excl);

  property p_bsy_has_brq;
    @(posedge clk) disable iff (rst) bsy_q |-> brq_q;
  endproperty
  a_bsy_has_brq: assert property (p_bsy_has_brq);

endmodule

// File: tb/tb_gtm.sv
// Testbench for gtm: directed scenarios with literal expectations, then
// randomized traffic, all continuously checked against a timestamp-based model.
module tb_gtm;

  localparam int SZ   = 8;
  localparam int WS   = 4;
  localparam int WMAX = (1 << WS) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [SZ-1:0] per;
  logic          bac;
  logic          eac;
  logic          brq, erq, bsy, rdy, tmo;

  int n_cmp = 0;
  int n_bad = 0;

  gtm #(.size(SZ), .wsize(WS)) dut (
    .clk(clk), .rst(rst), .run(run), .per(per), .bac(bac), .eac(eac),
    .brq(brq), .erq(erq), .bsy(bsy), .rdy(rdy), .tmo(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a measurement is described by the edge numbers at which
  // its milestones happened (start, begin ack, end ack, timeout). The request
  // outputs follow from those timestamps and the effective period.
  longint e_n   = 0;
  bit     m_act = 0;
  longint m_per = 1;
  longint t_arm = -1, t_bac = -1, t_eac = -1, t_tmo = -1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_n   <= 0;
      m_act <= 0;
      t_arm <= -1;
      t_bac <= -1;
      t_eac <= -1;
      t_tmo <= -1;
    end else begin
      e_n <= e_n + 1;
      if (!run) begin
        m_act <= 0;
      end else if (!m_act) begin
        m_act <= 1;
        t_arm <= e_n + 1;
        m_per <= (per == 0) ? 1 : longint'(per);
        t_bac <= -1;
        t_eac <= -1;
        t_tmo <= -1;
      end else if (t_tmo < 0 && t_eac < 0) begin
        if (t_bac < 0) begin
          if (bac) t_bac <= e_n + 1;
          else if (e_n + 1 - t_arm == WMAX) t_tmo <= e_n + 1;
        end else if (e_n + 1 > t_bac + m_per) begin
          if (eac) t_eac <= e_n + 1;
          else if (e_n + 1 - (t_bac + m_per) == WMAX) t_tmo <= e_n + 1;
        end
      end
    end
  end

  logic [4:0] exp_v, act_v;
  always @(negedge clk) begin
    exp_v[4] = m_act && t_tmo < 0;
    exp_v[3] = m_act && t_tmo < 0 && t_bac >= 0 && e_n >= t_bac + m_per;
    exp_v[2] = m_act && t_tmo < 0 && t_eac < 0;
    exp_v[1] = m_act && t_eac >= 0;
    exp_v[0] = m_act && t_tmo >= 0;
    act_v    = {brq, erq, bsy, rdy, tmo};
    chk("cycle_outputs{brq,erq,bsy,rdy,tmo}", 32'(act_v), 32'(exp_v));
  end

  // Counts edges after the sampling edge until erq rises.
  task automatic count_erq(input string nm, input int exp_cnt);
    int cnt;
    cnt = 0;
    while (!erq && cnt < 400) begin
      tick();
      cnt++;
    end
    chk(nm, cnt, exp_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int p_bac, p_eac, p_run;
    rst = 1'b1; run = 1'b0; per = '0; bac = 1'b0; eac = 1'b0;
    repeat (2) tick();
    chk("reset_outputs", 32'({brq, erq, bsy, rdy, tmo}), 0);
    rst = 1'b0;

    // Acknowledges while idle are ignored.
    bac = 1'b1; eac = 1'b1;
    repeat (2) tick();
    chk("idle_ignores_acks", 32'({brq, erq, bsy, rdy, tmo}), 0);
    bac = 1'b0; eac = 1'b0;

    // per=5, bac two cycles after brq, eac three cycles after erq.
    per = 8'd5; run = 1'b1;
    tick();
    chk("arm_brq_bsy", 32'({brq, bsy, erq}), 32'(3'b110));
    per = 8'd77;
    repeat (2) tick();
    bac = 1'b1; tick(); bac = 1'b0;
    count_erq("per5_erq_latency", 5);
    repeat (2) tick();
    eac = 1'b1; tick(); eac = 1'b0;
    chk("per5_done_outs{brq,erq,bsy,rdy,tmo}", 32'({brq, erq, bsy, rdy, tmo}), 32'(5'b11010));
    repeat (3) tick();
    chk("done_held_no_restart", 32'({brq, erq, rdy}), 32'(3'b111));
    run = 1'b0; tick();
    chk("done_to_idle", 32'({brq, erq, bsy, rdy, tmo}), 0);

    // per=0 behaves as per=1.
    per = 8'd0; run = 1'b1;
    tick();
    bac = 1'b1; tick(); bac = 1'b0;
    count_erq("per0_erq_latency", 1);
    eac = 1'b1; tick(); eac = 1'b0;
    chk("per0_rdy", 32'(rdy), 1);
    run = 1'b0; tick();

    // No begin acknowledge: timeout after WMAX cycles in ARM.
    per = 8'd3; run = 1'b1;
    tick();
    cnt = 0;
    while (!tmo && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("arm_timeout_cycles", cnt, WMAX);
    chk("err_brq_low", 32'({brq, bsy}), 0);
    run = 1'b0; tick();
    chk("err_cleared", 32'(tmo), 0);

    // Maximum period; end acknowledge on the very last STOP cycle wins.
    per = 8'd255; run = 1'b1;
    tick();
    bac = 1'b1; tick(); bac = 1'b0;
    count_erq("per255_erq_latency", 255);
    repeat (WMAX - 1) tick();
    chk("stop_last_cycle_still_waiting", 32'({bsy, tmo}), 32'(2'b10));
    eac = 1'b1; tick(); eac = 1'b0;
    chk("eac_on_timeout_cycle{rdy,tmo}", 32'({rdy, tmo}), 32'(2'b10));
    run = 1'b0; tick();

    // run dropped mid-gate, then a fresh measurement with the full period.
    per = 8'd100; run = 1'b1;
    tick();
    bac = 1'b1; tick();
    repeat (40) tick();
    chk("mid_gate_state{brq,erq}", 32'({brq, erq}), 32'(2'b10));
    run = 1'b0; tick();
    chk("abort_outputs", 32'({brq, erq, bsy, rdy, tmo}), 0);
    bac = 1'b0; run = 1'b1; tick();
    chk("rearm_brq", 32'({brq, erq}), 32'(2'b10));
    bac = 1'b1; tick(); bac = 1'b0;
    count_erq("rearm_erq_latency", 100);

    // Asynchronous reset while in STOP, no clock edge involved.
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", 32'({brq, erq, bsy, rdy, tmo}), 0);
    rst = 1'b0;
    tick();
    chk("run_high_at_release_arms", 32'({brq, erq, bsy}), 32'(3'b101));
    run = 1'b0; tick();

    // Randomized traffic with varying acknowledge rates, checked by the model.
    for (int seg = 0; seg < 8; seg++) begin
      p_bac = $urandom_range(5, 60);
      p_eac = $urandom_range(5, 60);
      p_run = $urandom_range(1, 5);
      for (int i = 0; i < 500; i++) begin
        run = ($urandom_range(0, 99) >= p_run);
        bac = ($urandom_range(0, 99) < p_bac);
        eac = ($urandom_range(0, 99) < p_eac);
        per = ($urandom_range(0, 49) == 0) ? 8'(255) : 8'($urandom_range(0, 12));
        if ($urandom_range(0, 399) == 0) begin
          #1 rst = 1'b1;
          #2 rst = 1'b0;
        end
        tick();
      end
    end
    run = 1'b0; bac = 1'b0; eac = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
